// File: rtl/mem_ctrl_if.sv
// Bus bundle between mem_ctrl, its two clients (fetcher, load/store buffer)
// and the 8-bit RAM/IO port.
//
// Handshake: requests are levels. A client raises *_req with its address/len/
// data fields stable and holds them until it sees its one-cycle completion
// pulse (inst_MC_flag or ls_done). It drops the request during that pulse
// cycle. The controller may accept a new request at the edge that ends the
// pulse cycle. At most one pulse is high per cycle.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              jump_wrong;
    logic              inst_MC_req;
    logic [ADDR_W-1:0] inst_MC_addr;
    logic              inst_MC_flag;
    logic [31:0]       inst_MC;
    logic              ls_req;
    logic              ls_wr;
    logic [1:0]        ls_len;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;
    logic              io_buffer_full;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic [1:0]        dbg_state;   // controller FSM state, for observation only

    modport slave (
        input  rdy, jump_wrong,
        input  inst_MC_req, inst_MC_addr,
        output inst_MC_flag, inst_MC,
        input  ls_req, ls_wr, ls_len, ls_addr, ls_wdata,
        output ls_done, ls_rdata,
        input  io_buffer_full, mem_din,
        output mem_dout, mem_a, mem_wr,
        output dbg_state
    );

    modport master (
        output rdy, jump_wrong,
        output inst_MC_req, inst_MC_addr,
        input  inst_MC_flag, inst_MC,
        output ls_req, ls_wr, ls_len, ls_addr, ls_wdata,
        input  ls_done, ls_rdata,
        output io_buffer_full, mem_din,
        input  mem_dout, mem_a, mem_wr,
        input  dbg_state
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: serialises fetcher word reads and load/store accesses
// into byte cycles on the 8-bit RAM/IO bus, little-endian, LSB first.
// A read byte is sampled from mem_din at the edge that ends the cycle in
// which its address was driven; one extra cycle follows the last byte before
// the completion pulse.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IFETCH = 2'd1,
        S_LOAD   = 2'd2,
        S_STORE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic              inst_flag_q, inst_flag_d;
    logic [31:0]       inst_data_q, inst_data_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic              store_blocked;

    // IO window stores wait while the UART buffer is full
    assign store_blocked = (addr_q[17:16] == 2'b11) && bus.io_buffer_full;

    // State and datapath registers; rdy low freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            len_q       <= 2'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            inst_flag_q <= 1'b0;
            inst_data_q <= 32'd0;
            ls_done_q   <= 1'b0;
            ls_rdata_q  <= 32'd0;
        end else if (bus.rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            inst_flag_q <= inst_flag_d;
            inst_data_q <= inst_data_d;
            ls_done_q   <= ls_done_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    // Next-state: arbitration, byte stepping, aborts and completion pulses
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        inst_flag_d = 1'b0;
        inst_data_d = inst_data_q;
        ls_done_d   = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            S_IDLE: begin
                // A flush in the same cycle suppresses any acceptance
                if (!bus.jump_wrong) begin
                    if (bus.ls_req) begin
                        state_d = bus.ls_wr ? S_STORE : S_LOAD;
                        addr_d  = bus.ls_addr;
                        len_d   = (bus.ls_len == 2'd2) ? 2'd3 : bus.ls_len;
                        wdata_d = bus.ls_wdata;
                        cnt_d   = 3'd0;
                        buf_d   = 32'd0;
                    end else if (bus.inst_MC_req) begin
                        state_d = S_IFETCH;
                        addr_d  = bus.inst_MC_addr;
                        len_d   = 2'd3;
                        cnt_d   = 3'd0;
                        buf_d   = 32'd0;
                    end
                end
            end
            S_IFETCH, S_LOAD: begin
                if (bus.jump_wrong) begin
                    // Speculative read dropped, partial bytes discarded
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                    buf_d   = 32'd0;
                end else if (cnt_q <= {1'b0, len_q}) begin
                    buf_d[{cnt_q[1:0], 3'b000} +: 8] = bus.mem_din;
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    // Bytes above len stay zero because buf was cleared on accept
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                    if (state_q == S_IFETCH) begin
                        inst_flag_d = 1'b1;
                        inst_data_d = buf_q;
                    end else begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = buf_q;
                    end
                end
            end
            S_STORE: begin
                // Stores are committed: jump_wrong has no effect here
                if (!store_blocked) begin
                    if (cnt_q[1:0] == len_q) begin
                        state_d   = S_IDLE;
                        cnt_d     = 3'd0;
                        ls_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs: address/data per byte cycle, write strobe gated by rdy
    always_comb begin
        bus.mem_a    = '0;
        bus.mem_dout = 8'd0;
        bus.mem_wr   = 1'b0;
        case (state_q)
            S_IFETCH, S_LOAD: begin
                bus.mem_a = addr_q + ADDR_W'(cnt_q);
            end
            S_STORE: begin
                bus.mem_a    = addr_q + ADDR_W'(cnt_q);
                bus.mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                bus.mem_wr   = bus.rdy && !store_blocked;
            end
            default: ;
        endcase
    end

    assign bus.inst_MC_flag = inst_flag_q;
    assign bus.inst_MC      = inst_data_q;
    assign bus.ls_done      = ls_done_q;
    assign bus.ls_rdata     = ls_rdata_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-addressed RAM model, table of accesses with
// expected data and latency, hand-written flush/IO/reset/stall sequences.
module tb_mem_ctrl;
    localparam int AW = 32;
    localparam int W  = 34;   // {check_data, is_ls, data}

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(AW)) bus ();
    mem_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // RAM model: 64 KiB, address taken modulo 2^16 (so the 32-bit wrap aliases consistently)
    logic [7:0] ram [0:65535];
    assign bus.mem_din = ram[bus.mem_a[15:0]];
    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
    end

    logic [W-1:0] exp_q[$];
    logic [39:0]  wr_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_ls;
        bit          wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse and write monitor, sampled mid-cycle
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            if (bus.inst_MC_flag && bus.ls_done) check("pulse_overlap", 40'd1, 40'd0);
            if (bus.inst_MC_flag || bus.ls_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 40'(bus.inst_MC_flag) + 40'(bus.ls_done), 40'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 40'(bus.ls_done), 40'(e[32]));
                    if (e[33]) begin
                        if (e[32]) check("ls_rdata", 40'(bus.ls_rdata), 40'(e[31:0]));
                        else       check("inst_MC", 40'(bus.inst_MC), 40'(e[31:0]));
                    end
                end
            end
            if (bus.mem_wr) begin
                if (wr_q.size() == 0) check("unexpected_write", {bus.mem_a, bus.mem_dout}, 40'hFF_FFFF_FFFF);
                else                  check("mem_write", {bus.mem_a, bus.mem_dout}, wr_q.pop_front());
            end
            if (!bus.rdy) check("wr_while_frozen", 40'(bus.mem_wr), 40'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_ls(input bit wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
        bus.ls_req   = 1'b1;
        bus.ls_wr    = wr;
        bus.ls_len   = len;
        bus.ls_addr  = a;
        bus.ls_wdata = d;
    endtask

    task automatic drive_fetch(input logic [31:0] a);
        bus.inst_MC_req  = 1'b1;
        bus.inst_MC_addr = a;
    endtask

    task automatic push_res(input bit is_ls, input logic [31:0] d);
        exp_q.push_back({1'b1, is_ls, d});
    endtask

    task automatic push_store(input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = (len == 2'd2) ? 4 : int'(len) + 1;
        for (int k = 0; k < n; k++) wr_q.push_back({a + 32'(k), d[8*k +: 8]});
        exp_q.push_back({1'b0, 1'b1, 32'd0});
    endtask

    // Waits for the client's pulse, drops its request in the pulse cycle
    task automatic wait_pulse(input bit is_ls, output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (is_ls ? bus.ls_done : bus.inst_MC_flag) begin
                lat = c;
                if (is_ls) bus.ls_req = 1'b0;
                else       bus.inst_MC_req = 1'b0;
                break;
            end
        end
        if (lat == 0) check(is_ls ? "ls_timeout" : "fetch_timeout", 40'd1, 40'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_inst_flag"}, 40'(bus.inst_MC_flag), 40'd0);
        check({tag, "_inst_MC"},   40'(bus.inst_MC), 40'd0);
        check({tag, "_ls_done"},   40'(bus.ls_done), 40'd0);
        check({tag, "_ls_rdata"},  40'(bus.ls_rdata), 40'd0);
        check({tag, "_mem_a"},     40'(bus.mem_a), 40'd0);
        check({tag, "_mem_wr"},    40'(bus.mem_wr), 40'd0);
        check({tag, "_mem_dout"},  40'(bus.mem_dout), 40'd0);
        check({tag, "_state"},     40'(bus.dbg_state), 40'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] d, a, m;
        logic [1:0]  ln;

        tbl[0]  = '{0, 0, 2'd3, 32'h0000_0100, 32'h0,         32'h0000_0513, 6};
        tbl[1]  = '{1, 0, 2'd3, 32'h0000_0200, 32'h0,         32'h1234_5678, 6};
        tbl[2]  = '{1, 1, 2'd1, 32'h0000_1004, 32'h0000_ABCD, 32'h0,         3};
        tbl[3]  = '{1, 0, 2'd1, 32'h0000_1004, 32'h0,         32'h0000_ABCD, 4};
        tbl[4]  = '{1, 0, 2'd0, 32'h0000_1005, 32'h0,         32'h0000_00AB, 3};
        tbl[5]  = '{1, 1, 2'd3, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0,         5};
        tbl[6]  = '{1, 0, 2'd0, 32'h0000_2003, 32'h0,         32'h0000_00DE, 3};
        tbl[7]  = '{1, 1, 2'd2, 32'h0000_3000, 32'hCAFE_F00D, 32'h0,         5};
        tbl[8]  = '{1, 0, 2'd3, 32'h0000_3000, 32'h0,         32'hCAFE_F00D, 6};
        tbl[9]  = '{1, 1, 2'd3, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0,         5};
        tbl[10] = '{1, 0, 2'd3, 32'hFFFF_FFFE, 32'h0,         32'h1122_3344, 6};
        tbl[11] = '{1, 0, 2'd0, 32'h0000_0000, 32'h0,         32'h0000_0022, 3};

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
        ram[16'h0200] = 8'h78; ram[16'h0201] = 8'h56; ram[16'h0202] = 8'h34; ram[16'h0203] = 8'h12;
        ram[16'h0040] = 8'h93; ram[16'h0041] = 8'h00; ram[16'h0042] = 8'h10; ram[16'h0043] = 8'h00;

        bus.rdy = 1'b1; bus.jump_wrong = 1'b0; bus.io_buffer_full = 1'b0;
        bus.inst_MC_req = 1'b0; bus.inst_MC_addr = '0;
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_len = 2'd0; bus.ls_addr = '0; bus.ls_wdata = '0;

        // Reset state
        tick(); tick(); tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Table of single accesses: data via scoreboard, latency here
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].is_ls) begin
                drive_ls(tbl[i].wr, tbl[i].len, tbl[i].addr, tbl[i].wdata);
                if (tbl[i].wr) push_store(tbl[i].len, tbl[i].addr, tbl[i].wdata);
                else           push_res(1'b1, tbl[i].exp_data);
            end else begin
                drive_fetch(tbl[i].addr);
                push_res(1'b0, tbl[i].exp_data);
            end
            wait_pulse(tbl[i].is_ls, lat);
            check($sformatf("latency_%0d", i), 40'(lat), 40'(tbl[i].exp_lat));
        end

        // Same-edge requests: load wins, fetch follows after the done cycle
        drive_ls(1'b0, 2'd3, 32'h200, 32'h0);
        drive_fetch(32'h100);
        push_res(1'b1, 32'h1234_5678);
        push_res(1'b0, 32'h0000_0513);
        wait_pulse(1'b1, lat);
        check("arb_ls_lat", 40'(lat), 40'd6);
        wait_pulse(1'b0, lat);
        check("arb_fetch_lat", 40'(lat), 40'd6);

        // Flush during fetch byte cycle 2, then redirected fetch
        drive_fetch(32'h100);
        tick(); tick(); tick();
        bus.jump_wrong = 1'b1; bus.inst_MC_req = 1'b0;
        tick();
        check("flush_idle", 40'(bus.dbg_state), 40'd0);
        bus.jump_wrong = 1'b0;
        drive_fetch(32'h40);
        push_res(1'b0, 32'h0010_0093);
        wait_pulse(1'b0, lat);
        check("flush_refetch_lat", 40'(lat), 40'd6);

        // Flush in IDLE blocks acceptance on that edge
        drive_fetch(32'h40);
        bus.jump_wrong = 1'b1;
        tick();
        check("flush_blocks_accept", 40'(bus.dbg_state), 40'd0);
        bus.jump_wrong = 1'b0;
        push_res(1'b0, 32'h0010_0093);
        wait_pulse(1'b0, lat);
        check("after_block_lat", 40'(lat), 40'd6);

        // Flush during a store leaves it intact
        drive_ls(1'b1, 2'd3, 32'h5000, 32'h0BAD_F00D);
        push_store(2'd3, 32'h5000, 32'h0BAD_F00D);
        tick();
        bus.jump_wrong = 1'b1;
        tick();
        bus.jump_wrong = 1'b0;
        wait_pulse(1'b1, lat);
        check("store_flush_lat", 40'(lat), 40'd3);
        drive_ls(1'b0, 2'd3, 32'h5000, 32'h0);
        push_res(1'b1, 32'h0BAD_F00D);
        wait_pulse(1'b1, lat);

        // IO store held while the UART buffer is full
        bus.io_buffer_full = 1'b1;
        drive_ls(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041);
        push_store(2'd0, 32'h0003_0000, 32'h0000_0041);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("io_hold_wr", 40'(bus.mem_wr), 40'd0);
            check("io_hold_done", 40'(bus.ls_done), 40'd0);
        end
        bus.io_buffer_full = 1'b0;
        wait_pulse(1'b1, lat);
        check("io_release_lat", 40'(lat), 40'd1);

        // Reset mid-load: everything cleared, no pulse, re-request works
        drive_ls(1'b0, 2'd3, 32'h200, 32'h0);
        tick(); tick();
        rst = 1'b1; bus.ls_req = 1'b0;
        tick();
        check_zero("midrst");
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        drive_ls(1'b0, 2'd3, 32'h200, 32'h0);
        push_res(1'b1, 32'h1234_5678);
        wait_pulse(1'b1, lat);
        check("post_rst_lat", 40'(lat), 40'd6);

        // rdy stall for two edges mid-fetch delays the result by two cycles
        drive_fetch(32'h100);
        push_res(1'b0, 32'h0000_0513);
        tick(); tick();
        bus.rdy = 1'b0;
        tick(); tick();
        bus.rdy = 1'b1;
        wait_pulse(1'b0, lat);
        check("stall_fetch_lat", 40'(lat), 40'd4);

        // rdy stall mid-store: no duplicate byte writes
        drive_ls(1'b1, 2'd3, 32'h6000, 32'h5A5A_C3C3);
        push_store(2'd3, 32'h6000, 32'h5A5A_C3C3);
        tick();
        bus.rdy = 1'b0;
        tick(); tick();
        bus.rdy = 1'b1;
        wait_pulse(1'b1, lat);
        check("stall_store_lat", 40'(lat), 40'd4);

        // Random store / load-back pairs
        for (int i = 0; i < 6; i++) begin
            a  = 32'h7000 + 32'(i * 8);
            d  = $urandom;
            ln = 2'($urandom_range(0, 3));
            m  = (ln == 2'd0) ? 32'h0000_00FF : (ln == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            drive_ls(1'b1, ln, a, d);
            push_store(ln, a, d);
            wait_pulse(1'b1, lat);
            drive_ls(1'b0, ln, a, 32'h0);
            push_res(1'b1, d & m);
            wait_pulse(1'b1, lat);
        end

        tick(); tick();
        check("exp_q_drained", 40'(exp_q.size()), 40'd0);
        check("wr_q_drained", 40'(wr_q.size()), 40'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
